ahb_sram_slave: RTL and testbench



---
 rtl/ahb_pkg.sv | 19 +
 rtl/sram_bytelane.sv | 24 ++
 rtl/ahb_sram_slave.sv | 89 ++++++++
 tb/tb_ahb_sram_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and the byte-lane enable helper shared by the SRAM slave.
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic [2:0] HSIZE_DWORD   = 3'd3;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    function automatic logic [7:0] byte_enables(input logic [2:0] offset, input logic [2:0] size);
        logic [15:0] lanes;
        lanes = (16'd1 << (16'd1 << size)) - 16'd1;
        return 8'(lanes << offset);
    endfunction
endpackage

// File: rtl/sram_bytelane.sv
// sram_bytelane: single-port SRAM with synchronous read and per-byte write enables.
module sram_bytelane #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 1024,
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic [AW-1:0]           addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    we,
    output logic [DATA_WIDTH-1:0]   rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++)
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end else begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave in front of a byte-lane SRAM with programmable wait
// states, a one-cycle stall for write-then-read port conflicts and two-cycle ERROR replies.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LG = $clog2(NB);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_DATA = 3'd2, S_ERR1 = 3'd3, S_ERR2 = 3'd4;

    logic [2:0]            state, cnt;
    logic [AW-1:0]         addr_q, sram_addr;
    logic [NB-1:0]         be_q, be_n;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] hold_q, sram_rdata;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [7:0]            size_mask;
    logic                  ready, accept, legal, take, write_done, conflict, read_now, rd_phase;

    assign ready      = state != S_WAIT && state != S_ERR1;
    assign accept     = ready && HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign word_idx   = HADDR >> LG;
    assign size_mask  = 8'((16'd1 << HSIZE) - 16'd1);
    assign legal      = HSIZE <= 3'(LG) && (8'(HADDR[LG-1:0]) & size_mask) == 8'd0 &&
                        word_idx < ADDR_WIDTH'(DEPTH);
    assign take       = accept && legal;
    assign be_n       = NB'(byte_enables(3'(HADDR[LG-1:0]), HSIZE));
    assign write_done = state == S_DATA && wr_q;
    // A read colliding with a completing write is replayed from addr_q one cycle later.
    assign conflict   = take && !HWRITE && write_done;
    assign read_now   = take && !HWRITE && !write_done;
    assign rd_phase   = state == S_DATA && !wr_q;
    assign sram_addr  = read_now ? AW'(word_idx) : addr_q;

    assign HREADYOUT = ready;
    assign HRESP     = (state == S_ERR1 || state == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = rd_phase ? sram_rdata : hold_q;

    sram_bytelane #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_sram (
        .clk  (clk),
        .addr (sram_addr),
        .wdata(HWDATA),
        .be   (be_q),
        .we   (write_done),
        .rdata(sram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 3'd0;
            addr_q <= '0;
            be_q   <= '0;
            wr_q   <= 1'b0;
            hold_q <= '0;
        end else begin
            hold_q <= HRDATA;
            if (take) begin
                addr_q <= AW'(word_idx);
                be_q   <= be_n;
                wr_q   <= HWRITE;
            end
            cnt   <= state == S_WAIT ? cnt - 3'd1 : take ? 3'(WAIT_STATES) + 3'(conflict) : cnt;
            state <= state == S_WAIT ? (cnt == 3'd1 ? S_DATA : S_WAIT) :
                     state == S_ERR1 ? S_ERR2 :
                     !accept ? S_IDLE :
                     !legal ? S_ERR1 :
                     (WAIT_STATES > 0 || conflict) ? S_WAIT : S_DATA;
        end
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed AHB-Lite transfers against a transaction-level memory model,
// checked every cycle, plus literal checks on read data, stall and error cycle counts.
module tb_ahb_sram_slave;
    logic        clk = 1'b0, rst = 1'b1, which = 1'b0;
    logic        hsel = 1'b0, hwrite = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'd0;
    logic        ro0, ro2, rsp0, rsp2;
    logic [31:0] rd0, rd2;

    int total = 0, bad = 0, lows = 0, errs = 0;
    logic [31:0] last_rd;

    logic [31:0] mem [2][1024];
    logic [31:0] e_rd [2];
    logic        ph_v = 1'b0, ph_err, ph_wr;
    logic [3:0]  ph_be;
    int          ph_idx, ph_k, ph_low;

    logic        t_wr [16];
    logic [31:0] t_addr [16], t_data [16];
    logic [2:0]  t_size [16];
    int          nt = 0;

    ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .HSEL(hsel & ~which), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro0),
        .HREADYOUT(ro0), .HRESP(rsp0), .HRDATA(rd0)
    );
    ahb_sram_slave #(.WAIT_STATES(2)) dut2 (
        .clk(clk), .rst(rst), .HSEL(hsel & which), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro2),
        .HREADYOUT(ro2), .HRESP(rsp2), .HRDATA(rd2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Cycle monitor: outputs must follow the transaction model; also decides what the next edge does.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            ph_v = 1'b0;
            e_rd[0] = '0;
            e_rd[1] = '0;
        end else begin
            automatic int w = int'(which);
            automatic int ws = which ? 2 : 0;
            automatic logic rdy = which ? ro2 : ro0;
            automatic logic rsp = which ? rsp2 : rsp0;
            automatic logic [31:0] rd = which ? rd2 : rd0;
            automatic logic e_rdy = !ph_v || ph_k >= ph_low;
            automatic logic done, acc, conf;
            if (ph_v && !ph_err && !ph_wr && e_rdy) e_rd[w] = mem[w][ph_idx];
            chk("hreadyout", rdy, e_rdy);
            chk("hresp", rsp, ph_v && ph_err);
            chk("hrdata", rd, e_rd[w]);
            if (!rdy) lows++;
            if (rsp) errs++;
            if (ph_v && !ph_err && !ph_wr && rdy) last_rd = rd;
            done = ph_v && rdy;
            if (done && ph_wr && !ph_err)
                for (int b = 0; b < 4; b++)
                    if (ph_be[b]) mem[w][ph_idx][b*8 +: 8] = hwdata[b*8 +: 8];
            acc  = hsel && rdy && htrans[1];
            conf = acc && !hwrite && done && ph_wr && !ph_err;
            if (done) ph_v = 1'b0;
            else if (ph_v) ph_k++;
            if (acc) begin
                automatic int n = 1 << hsize;
                ph_v   = 1'b1;
                ph_k   = 0;
                ph_err = n > 4 || (haddr % n) != 0 || (haddr >> 2) >= 1024;
                ph_wr  = hwrite;
                ph_idx = int'(haddr >> 2);
                ph_be  = 4'(((1 << n) - 1) << haddr[1:0]);
                ph_low = ph_err ? 1 : ws + int'(conf);
            end
        end
    end

    task automatic add(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        t_wr[nt] = w;
        t_addr[nt] = a;
        t_size[nt] = s;
        t_data[nt] = d;
        nt++;
    endtask

    // Issues the queued transfers back to back, pipelining address and data phases.
    task automatic go();
        int g;
        logic r;
        last_rd = '1;
        for (int i = 0; i <= nt; i++) begin
            hsel   = i < nt;
            htrans = i < nt ? 2'b10 : 2'b00;
            if (i < nt) begin
                haddr  = t_addr[i];
                hwrite = t_wr[i];
                hsize  = t_size[i];
            end
            hwdata = i > 0 ? t_data[i-1] : 32'h0;
            g = 0;
            do begin
                @(negedge clk);
                r = which ? ro2 : ro0;
                @(posedge clk);
                g++;
            end while (!r && g < 20);
            #1;
            if (!r) begin
                total++;
                bad++;
                $display("FAIL ready_timeout: hreadyout stayed %b, want 1", r);
            end
        end
        nt = 0;
    endtask

    initial begin
        int l0, e0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready0", ro0, 1);
        chk("rst_resp0", rsp0, 0);
        chk("rst_rdata0", rd0, 0);
        chk("rst_ready2", ro2, 1);
        rst = 1'b0;

        l0 = lows; e0 = errs;
        add(1, 32'h10, 3'd2, 32'hDEADBEEF); go();
        add(0, 32'h10, 3'd2, 32'h0); go();
        chk("t1_rdata", last_rd, 32'hDEADBEEF);
        chk("t1_lows", lows - l0, 0);
        chk("t1_errs", errs - e0, 0);

        l0 = lows;
        add(1, 32'h20, 3'd2, 32'h11223344); go();
        add(1, 32'h21, 3'd0, 32'h0000AA00);
        add(1, 32'h22, 3'd1, 32'hBBCC0000); go();
        add(0, 32'h20, 3'd2, 32'h0); go();
        chk("t2_rdata", last_rd, 32'hBBCCAA44);
        chk("t2_lows", lows - l0, 0);

        l0 = lows;
        add(1, 32'h40, 3'd2, 32'h5A5A5A5A);
        add(0, 32'h40, 3'd2, 32'h0); go();
        chk("t3_rdata", last_rd, 32'h5A5A5A5A);
        chk("t3_lows", lows - l0, 1);
        l0 = lows;
        add(0, 32'h40, 3'd2, 32'h0);
        add(1, 32'h44, 3'd2, 32'h0F0F0F0F); go();
        chk("t3_rd_wr_lows", lows - l0, 0);

        which = 1'b1;
        add(1, 32'h0, 3'd2, 32'hCAFEF00D); go();
        l0 = lows;
        add(0, 32'h0, 3'd2, 32'h0); go();
        chk("t4_rdata", last_rd, 32'hCAFEF00D);
        chk("t4_lows", lows - l0, 2);
        l0 = lows;
        add(1, 32'h0, 3'd2, 32'h0BADC0DE);
        add(0, 32'h0, 3'd2, 32'h0); go();
        chk("t4_wr_rd_rdata", last_rd, 32'h0BADC0DE);
        chk("t4_wr_rd_lows", lows - l0, 5);
        which = 1'b0;

        add(1, 32'h0, 3'd2, 32'h01020304);
        add(1, 32'h8, 3'd2, 32'h05060708); go();
        l0 = lows; e0 = errs;
        add(1, 32'h2, 3'd2, 32'hFFFFFFFF);
        add(0, 32'h0, 3'd2, 32'h0); go();
        chk("t5_unaligned_errs", errs - e0, 2);
        chk("t5_unaligned_lows", lows - l0, 1);
        chk("t5_unaligned_keep", last_rd, 32'h01020304);
        e0 = errs;
        add(1, 32'h8, 3'd3, 32'hFFFFFFFF); go();
        add(0, 32'h8, 3'd2, 32'h0); go();
        chk("t5_oversize_errs", errs - e0, 2);
        chk("t5_oversize_keep", last_rd, 32'h05060708);
        e0 = errs;
        add(1, 32'h1000, 3'd2, 32'hFFFFFFFF); go();
        add(0, 32'h0, 3'd2, 32'h0); go();
        chk("t5_range_errs", errs - e0, 2);
        chk("t5_range_keep", last_rd, 32'h01020304);

        add(1, 32'h80, 3'd2, 32'h0); go();
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h80; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk);
        #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_ready", ro0, 1);
        chk("t6_rst_resp", rsp0, 0);
        chk("t6_rst_rdata", rd0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        add(0, 32'h80, 3'd2, 32'h0); go();
        chk("t6_no_write", last_rd, 32'h0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
